// File: rtl/req_codec_pkg.sv
// req_codec_pkg
// Shared constants and helpers for the 12-line request code path.
// Codes: 0 = no request, 1..12 = request line code-1, 13..15 = illegal.
// Contents:
//   N_REQ, CODE_W, CODE_NONE, CODE_MAX  - code space constants
//   code_to_mask(code)                  - one-hot of code-1, zero for 0 and 13..15
//   code_legal(code)                    - 1 for codes 0..12
package req_codec_pkg;

   localparam int                N_REQ     = 12;
   localparam int                CODE_W    = 4;
   localparam logic [CODE_W-1:0] CODE_NONE = 4'd0;
   localparam logic [CODE_W-1:0] CODE_MAX  = 4'd12;

   // Compare against every legal code so 0 and 13..15 fall out as an empty mask.
   function automatic logic [N_REQ-1:0] code_to_mask(input logic [CODE_W-1:0] code);
      logic [N_REQ-1:0] m;
      m = '0;
      for (int i = 0; i < N_REQ; i++)
         m[i] = (code == CODE_W'(i + 1));
      return m;
   endfunction

   function automatic logic code_legal(input logic [CODE_W-1:0] code);
      return (code <= CODE_MAX);
   endfunction

endpackage

// File: rtl/priority_encoder_12_4.sv
// priority_encoder_12_4
// Combinational 12-to-4 priority encoder; highest set bit wins.
// Ports:
//   r     in  12  request vector
//   code  out  4  k for highest set r[k-1], 0 when r is empty
module priority_encoder_12_4
   import req_codec_pkg::*;
(
   input  logic [N_REQ-1:0]  r,
   output logic [CODE_W-1:0] code
);

   // Ascending scan: later (higher) bits overwrite lower ones.
   always_comb begin
      code = CODE_NONE;
      for (int i = 0; i < N_REQ; i++)
         if (r[i]) code = CODE_W'(i + 1);
   end

endmodule

// File: rtl/req_popcount_12.sv
// req_popcount_12
// Combinational population count of a 12-bit vector.
// Ports:
//   vec  in  12  vector to count
//   cnt  out  4  number of set bits (0..12)
module req_popcount_12
   import req_codec_pkg::*;
(
   input  logic [N_REQ-1:0]  vec,
   output logic [CODE_W-1:0] cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < N_REQ; i++)
         cnt = cnt + {{(CODE_W-1){1'b0}}, vec[i]};
   end

endmodule

// File: rtl/req_vector_decoder_12.sv
// req_vector_decoder_12
// Rebuilds a registered 12-bit pending-request vector from request codes.
// Bits set by accepted in_code stay pending until cleared through clr_code.
// Optional feature macro: REQ_DECODER_TOP_EN adds top_code, the registered
// priority encoding of req.
// Ports:
//   clk        in   1   rising-edge clock
//   reset_n    in   1   asynchronous active-low reset
//   in_valid   in   1   request code valid
//   in_ready   out  1   pend_cnt below MAX_PENDING
//   in_code    in   4   0 no-op, 1..12 set bit code-1, 13..15 illegal
//   clr_valid  in   1   clear strobe (never back-pressured)
//   clr_code   in   4   bit to clear, same encoding as in_code
//   req        out  12  pending vector
//   req_any    out  1   OR of req
//   pend_cnt   out  4   popcount of req
//   err        out  1   sticky illegal-code flag
//   top_code   out  4   (REQ_DECODER_TOP_EN only) highest pending code, 0 if none
module req_vector_decoder_12
   import req_codec_pkg::*;
#(
   parameter int MAX_PENDING = 12
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic              clr_valid,
   input  logic [CODE_W-1:0] clr_code,
   output logic [N_REQ-1:0]  req,
   output logic              req_any,
   output logic [CODE_W-1:0] pend_cnt,
   output logic              err
`ifdef REQ_DECODER_TOP_EN
   ,
   output logic [CODE_W-1:0] top_code
`endif
);

   localparam logic [CODE_W-1:0] MAX_CNT = CODE_W'(MAX_PENDING);

   logic              accept;
   logic              illegal;
   logic [N_REQ-1:0]  set_mask;
   logic [N_REQ-1:0]  clr_mask;
   logic [N_REQ-1:0]  req_next;
   logic [CODE_W-1:0] cnt_next;

   // Ready looks only at registered occupancy; a same-cycle clear frees a
   // slot for the following cycle, not this one.
   assign in_ready = (pend_cnt < MAX_CNT);
   assign accept   = in_valid & in_ready;

   assign set_mask = accept    ? code_to_mask(in_code)  : '0;
   assign clr_mask = clr_valid ? code_to_mask(clr_code) : '0;
   assign illegal  = (accept & ~code_legal(in_code)) | (clr_valid & ~code_legal(clr_code));

   // Set is applied after clear so a same-bit collision leaves the bit pending.
   assign req_next = (req & ~clr_mask) | set_mask;

   req_popcount_12 u_popcount (
      .vec (req_next),
      .cnt (cnt_next)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req      <= '0;
         req_any  <= 1'b0;
         pend_cnt <= '0;
         err      <= 1'b0;
      end else begin
         req      <= req_next;
         req_any  <= |req_next;
         pend_cnt <= cnt_next;
         err      <= err | illegal;
      end
   end

`ifdef REQ_DECODER_TOP_EN
   logic [CODE_W-1:0] top_next;

   priority_encoder_12_4 u_top_enc (
      .r    (req_next),
      .code (top_next)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) top_code <= CODE_NONE;
      else          top_code <= top_next;
   end
`endif

endmodule
